// File: rtl/dmd_out_if.sv
// Row fetch handshake between the DMD transmitter and the frame store.
//   row_req   : transmitter asks for row row_addr; held until accepted
//   row_addr  : row being requested / transmitted, 0..31
//   row_data  : 128 pixels of the requested row, bit k = column k
//   row_valid : frame store presents row_data
// Handshake: a row is transferred on a clk edge where row_req=1 and
// row_valid=1. row_req drops on that same edge. row_valid at any other time
// is ignored, and row_data is only sampled on the accepting edge.
interface dmd_out_if;
  logic         row_req;
  logic [4:0]   row_addr;
  logic [127:0] row_data;
  logic         row_valid;

  modport master (output row_req, output row_addr, input row_data, input row_valid);
  modport slave  (input row_req, input row_addr, output row_data, output row_valid);
endinterface

// File: rtl/dmd_out.sv
// dmd_out: transmit side of a WPC dot-matrix interface.
// Fetches one 128-pixel row at a time from the frame store, shifts it out on
// dmd_dotdata/dmd_dotclk (bit 0 first), then strobes dmd_rowclock (with
// dmd_firstrow on row 0) and dmd_latch, idles ROW_HOLD clks and moves on.
// Ports:
//   clk, reset_n  : single clock, asynchronous active-low reset
//   run           : level, 1 = scan frames continuously
//   row_if        : row fetch handshake (master side)
//   dmd_dotdata   : serial pixel, changes while dotclk is low
//   dmd_dotclk    : pixel clock, receiver samples on its rising edge
//   dmd_rowclock  : row advance strobe
//   dmd_firstrow  : high during the rowclock pulse of row 0
//   dmd_latch     : row latch strobe
//   dmd_enable    : display enable
//   frame_done    : one-clk pulse when the row 31 latch sequence completes
//   dbg_state     : current FSM state
// Build option: DMD_OUT_BLANK_EN blanks dmd_enable from rowclock start to
// the end of the latch gap to suppress ghosting during row changes.
module dmd_out #(
  parameter int CLK_DIV  = 4,
  parameter int ROWCLK_W = 2,
  parameter int LATCH_W  = 2,
  parameter int ROW_HOLD = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  dmd_out_if.master  row_if,
  output logic       dmd_dotdata,
  output logic       dmd_dotclk,
  output logic       dmd_rowclock,
  output logic       dmd_firstrow,
  output logic       dmd_latch,
  output logic       dmd_enable,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_ROWCLK = 3'd3,
    ST_LATCH  = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  localparam int PW   = (ROWCLK_W > LATCH_W) ? ROWCLK_W : LATCH_W;
  localparam int CMAX = (PW > ROW_HOLD) ? PW : ROW_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = $clog2(CLK_DIV + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] RC_LAST   = CW'(ROWCLK_W - 1);
  localparam logic [CW-1:0] RC_GAP    = CW'(ROWCLK_W);
  localparam logic [CW-1:0] LT_LAST   = CW'(LATCH_W - 1);
  localparam logic [CW-1:0] LT_GAP    = CW'(LATCH_W);
  localparam logic [CW-1:0] HOLD_LAST = CW'(ROW_HOLD - 1);

  state_t         state;
  logic [127:0]   shreg;
  logic [DW-1:0]  div_cnt;   // clks within one dotclk half-period
  logic [7:0]     half_cnt;  // half-period index 0..255; even = low, odd = high
  logic [CW-1:0]  cnt;       // pulse / gap / hold timer
  logic           row_req_q;
  logic [4:0]     row_addr_q;

  assign row_if.row_req  = row_req_q;
  assign row_if.row_addr = row_addr_q;
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      div_cnt      <= '0;
      half_cnt     <= '0;
      cnt          <= '0;
      row_req_q    <= 1'b0;
      row_addr_q   <= '0;
      dmd_dotdata  <= 1'b0;
      dmd_dotclk   <= 1'b0;
      dmd_rowclock <= 1'b0;
      dmd_firstrow <= 1'b0;
      dmd_latch    <= 1'b0;
      dmd_enable   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // row_addr is kept so a stopped scan resumes where it left off
          if (run) begin
            state      <= ST_FETCH;
            row_req_q  <= 1'b1;
            dmd_enable <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (row_req_q && row_if.row_valid) begin
            shreg       <= row_if.row_data;
            dmd_dotdata <= row_if.row_data[0];
            dmd_dotclk  <= 1'b0;
            row_req_q   <= 1'b0;
            div_cnt     <= '0;
            half_cnt    <= '0;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == 8'hFF) begin
              dmd_dotclk   <= 1'b0;
              dmd_dotdata  <= 1'b0;
              dmd_rowclock <= 1'b1;
              dmd_firstrow <= (row_addr_q == 5'd0);
              cnt          <= '0;
              state        <= ST_ROWCLK;
`ifdef DMD_OUT_BLANK_EN
              dmd_enable   <= 1'b0;
`endif
            end else begin
              half_cnt   <= half_cnt + 8'd1;
              dmd_dotclk <= ~half_cnt[0];
              // leaving a high half: present the next bit at the start of low
              if (half_cnt[0]) begin
                shreg       <= {1'b0, shreg[127:1]};
                dmd_dotdata <= shreg[1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        ST_ROWCLK: begin
          if (cnt == RC_GAP) begin
            dmd_latch <= 1'b1;
            cnt       <= '0;
            state     <= ST_LATCH;
          end else begin
            if (cnt == RC_LAST) begin
              dmd_rowclock <= 1'b0;
              dmd_firstrow <= 1'b0;
            end
            cnt <= cnt + CW'(1);
          end
        end
        ST_LATCH: begin
          if (cnt == LT_GAP) begin
            row_addr_q <= row_addr_q + 5'd1;
            frame_done <= (row_addr_q == 5'd31);
            cnt        <= '0;
            state      <= ST_HOLD;
`ifdef DMD_OUT_BLANK_EN
            dmd_enable <= 1'b1;
`endif
          end else begin
            if (cnt == LT_LAST) dmd_latch <= 1'b0;
            cnt <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (run) begin
              row_req_q <= 1'b1;
              state     <= ST_FETCH;
            end else begin
              dmd_enable <= 1'b0;
              state      <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
